// File: rtl/sr_sequencer.sv
// Multi-cycle shift/rotate sequencer. An accepted operation takes one
// one-bit step per RUN cycle on a working copy of the operand. Result and
// flags are registered together when the FSM enters DONE.
module sr_sequencer #(
  parameter int COUNT_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] control,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       abort,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] res,
  output logic [3:0] flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q;
  logic [7:0]           work_q;
  logic [2:0]           ctrl_q;
  logic                 a7_q;
  logic                 cf_q;
  logic [7:0]           res_q;
  logic [3:0]           flags_q;

  logic [3:0]           n_eff;
  logic                 accept;
  logic                 run_step;
  logic                 finish;
  logic [7:0]           step_w;
  logic                 step_cf;

  // Effective step count: shifts saturate at 9 (nothing changes past that),
  // rotates only need the amount modulo 8.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    n_eff = 4'd0;
    if (control[2]) begin
      n_eff = {1'b0, B[2:0]};
    end else if (B > 8'd9) begin
      n_eff = 4'd9;
    end else begin
      n_eff = B[3:0];
    end
  end

  // Next-state logic plus the datapath strobes derived from it.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    run_step = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort here; abort is not looked at.
        if (start) begin
          accept  = 1'b1;
          state_d = (n_eff == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          run_step = 1'b1;
          if (count_q == COUNT_W'(1)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-bit step on the working register for the latched operation.
  always_comb begin
    step_w  = work_q;
    step_cf = cf_q;
    casez (ctrl_q)
      3'b000: begin step_w = {a7_q, work_q[7:1]};    step_cf = work_q[0]; end
      3'b001: begin step_w = {1'b0, work_q[7:1]};    step_cf = work_q[0]; end
      3'b01?: begin step_w = {work_q[6:0], 1'b0};    step_cf = work_q[7]; end
      3'b1?0: step_w = {work_q[6:0], work_q[7]};
      3'b1?1: step_w = {work_q[0], work_q[7:1]};
      default: step_w = work_q;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operand capture, per-cycle stepping and result/flag loading on entry to DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      work_q  <= 8'h00;
      ctrl_q  <= 3'b000;
      a7_q    <= 1'b0;
      cf_q    <= 1'b0;
      res_q   <= 8'h00;
      flags_q <= 4'b0000;
    end else if (accept) begin
      work_q  <= A;
      ctrl_q  <= control;
      a7_q    <= A[7];
      cf_q    <= 1'b0;
      count_q <= COUNT_W'(n_eff);
      if (n_eff == 4'd0) begin
        // Zero-step result: cf=0 and of=A[7]^A[7]=0 for shifts, 0 for rotates.
        res_q   <= A;
        flags_q <= {1'b0, (A == 8'h00), A[7], 1'b0};
      end
    end else if (run_step) begin
      work_q  <= step_w;
      cf_q    <= step_cf;
      count_q <= count_q - COUNT_W'(1);
      if (finish) begin
        res_q   <= step_w;
        flags_q <= {ctrl_q[2] ? 1'b0 : step_cf,
                    (step_w == 8'h00),
                    step_w[7],
                    ctrl_q[2] ? 1'b0 : (step_w[7] ^ a7_q)};
      end
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign res   = res_q;
  assign flags = flags_q;

endmodule

// File: doc/sr_sequencer.md
SR_SEQUENCER -- requirements
Module: sr_sequencer

Interface
REQ-001 The block SHALL have the parameter COUNT_W, default 4, which sets the width of the internal iteration counter (minimum 4, so it can hold 9).
REQ-002 The block SHALL have the port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have the port start  input  1  requests an operation; accepted only when ready=1.
REQ-005 The block SHALL have the port control  input  3  operation select: 000 SAR, 001 SHR, 010 SAL, 011 SHL, 1x0 ROL, 1x1 ROR.
REQ-006 The block SHALL have the port A  input  8  the operand.
REQ-007 The block SHALL have the port B  input  8  the unsigned shift or rotate amount.
REQ-008 The block SHALL have the port abort  input  1  cancels an operation in progress.
REQ-009 The block SHALL have the port ready  output  1  high in IDLE only.
REQ-010 The block SHALL have the port busy  output  1  high in RUN only.
REQ-011 The block SHALL have the port done  output  1  one-cycle pulse in DONE; res and flags are valid in that cycle.
REQ-012 The block SHALL have the port res  output  8  the result, registered.
REQ-013 The block SHALL have the port flags  output  4  {cf, zf, sf, of}, registered.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, with the following transitions:
- IDLE -> RUN on start when N>0.
- IDLE -> DONE on start when N=0.
- RUN -> DONE when the counter reaches 0.
- DONE -> IDLE unconditionally.
REQ-015 On acceptance the block SHALL latch A into a working register, latch control, and clear cf.
REQ-016 The effective count N SHALL be:
- for shifts: min(B, 9), because further steps do not change res or cf;
- for rotates: B[2:0].
REQ-017 Each RUN cycle SHALL perform a one-bit step on the working register, then decrement the counter.
REQ-018 The one-bit steps SHALL be:
- SHR: shift in 0 at the MSB; cf gets the bit shifted out of the LSB.
- SAR: shift in A[7] at the MSB; cf gets the bit shifted out of the LSB.
- SAL and SHL (identical): shift in 0 at the LSB; cf gets the bit shifted out of the MSB.
- ROL and ROR: circular rotate; cf unchanged.
REQ-019 Latency SHALL be exactly N+1 cycles: done is asserted N+1 cycles after the cycle in which start was accepted.
REQ-020 On the transition into DONE, res and flags SHALL be loaded together as follows:
- res = the working register;
- zf = (res == 0);
- sf = res[7];
- shifts: cf = the last bit shifted out (0 when N=0), of = res[7] XOR A[7];
- rotates: cf = 0 and of = 0.
REQ-021 res and flags SHALL hold their values from DONE until the next DONE.
REQ-022 start SHALL be ignored while in RUN or DONE; a start pulse in those states is not queued.
REQ-023 The block SHALL sample control, A and B only in the acceptance cycle; later changes to them have no effect.
REQ-024 abort in RUN SHALL force the next state to IDLE with no done pulse, leaving res and flags unchanged.
REQ-025 abort SHALL be ignored in IDLE and DONE.
REQ-026 When start and abort are both high in IDLE, start SHALL win.

Reset
REQ-027 While reset_n=0 at a rising edge, the block SHALL load state=IDLE, counter=0, working register=0, res=0x00, flags=0000 and done=0, from the next cycle.
REQ-028 After reset the block SHALL present ready=1 and busy=0.
REQ-029 Reset SHALL override start and abort.
REQ-030 Reset asserted in RUN or DONE SHALL discard the operation, with no done pulse.

Verification
REQ-031 SHL with A=0x81, B=1 -> done 2 cycles after start; res=0x02; flags cf=1, zf=0, sf=0, of=1.
REQ-032 SAR with A=0x80, B=3 -> done 4 cycles after start; res=0xF0; flags cf=0, zf=0, sf=1, of=0.
REQ-033 SHR with A=0xFF, B=200 -> N=9, done 10 cycles after start; res=0x00; flags cf=0, zf=1, sf=0, of=1.
REQ-034 ROR with A=0x01, B=9 -> done 2 cycles after start; res=0x80; flags cf=0, zf=0, sf=1, of=0; ROL with A=0x01, B=8 -> done next cycle; res=0x01.
REQ-035 Sequence: start SHL with A=0x00, B=0 -> done next cycle, res=0x00, flags cf=0, zf=1, sf=0, of=0; then start with B=5, pulse start again mid-RUN -> exactly one done pulse; then start again and pulse abort in the 2nd RUN cycle -> no done, return to IDLE, res unchanged.
REQ-036 Reset asserted (reset_n=0) in the 3rd RUN cycle of an SHR with B=8 -> next cycle state=IDLE, res=0x00, flags=0000, ready=1, and no done pulse.
